// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: one FSM per channel decides when its gated clock runs,
// and a low-transparent latch + AND cell makes each GATED_CLK glitch-free.
module clk_gate_ctrl #(
  parameter int NCH      = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_DLY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TEST_EN,
  input  logic [NCH-1:0]    CH_EN,
  input  logic [NCH-1:0]    AUTO_EN,
  input  logic [NCH-1:0]    BUSY,
  input  logic [NCH-1:0]    REQ,
  input  logic [IDLE_W-1:0] IDLE_LIMIT,
  output logic [NCH-1:0]    ACK,
  output logic [NCH-1:0]    CLK_ON,
  output logic [NCH-1:0]    GATED_CLK
);

  localparam int                WCNT_W    = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_DLY - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = {IDLE_W{1'b1}};

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  state_e              state_q [NCH];
  state_e              state_d [NCH];
  logic [WCNT_W-1:0]   wake_q  [NCH];
  logic [WCNT_W-1:0]   wake_d  [NCH];
  logic [IDLE_W-1:0]   idle_q  [NCH];
  logic [IDLE_W-1:0]   idle_d  [NCH];
  logic [NCH-1:0]      en_q;
  logic [NCH-1:0]      en_d;
  logic [NCH-1:0]      latch_q;
  logic [NCH-1:0]      want_clk;

  // Any reason to keep (or bring up) the clock, ignoring software permission.
  assign want_clk = REQ | BUSY | ~AUTO_EN;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      wake_d[i]  = wake_q[i];
      idle_d[i]  = idle_q[i];
      if (!CH_EN[i]) begin
        state_d[i] = ST_OFF;
      end else begin
        case (state_q[i])
          ST_OFF: begin
            if (want_clk[i]) begin
              state_d[i] = ST_WAKE;
              wake_d[i]  = '0;
            end
          end
          ST_WAKE: begin
            if (wake_q[i] == WAKE_LAST) state_d[i] = ST_ON;
            else                        wake_d[i]  = wake_q[i] + 1'b1;
          end
          ST_ON: begin
            if (!want_clk[i]) begin
              state_d[i] = ST_IDLE;
              idle_d[i]  = '0;
            end
          end
          ST_IDLE: begin
            if (want_clk[i]) begin
              state_d[i] = ST_ON;
              idle_d[i]  = '0;
            end else if (idle_q[i] >= IDLE_LIMIT) begin
              state_d[i] = ST_OFF;
            end else if (idle_q[i] != IDLE_MAX) begin
              idle_d[i]  = idle_q[i] + 1'b1;
            end
          end
          default: state_d[i] = ST_OFF;
        endcase
      end
      en_d[i] = (state_d[i] != ST_OFF);
      ACK[i]  = REQ[i] & (state_q[i] == ST_ON);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_OFF;
        wake_q[i]  <= '0;
        idle_q[i]  <= '0;
      end
      en_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        wake_q[i]  <= wake_d[i];
        idle_q[i]  <= idle_d[i];
      end
      en_q <= en_d;
    end
  end

  // Deliberately not reset: a high phase in flight when RST rises must finish at full width.
  always_latch begin
    if (!CLK) latch_q <= en_q | {NCH{TEST_EN}};
  end

  assign GATED_CLK = {NCH{CLK}} & latch_q;
  assign CLK_ON    = en_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed scenarios then random stimulus, scored against a
// queue of expectations produced by an abstract per-channel model.
module tb_clk_gate_ctrl;

  localparam int NCH      = 4;
  localparam int IDLE_W   = 8;
  localparam int WAKE_DLY = 2;

  logic              CLK;
  logic              RST;
  logic              TEST_EN;
  logic [NCH-1:0]    CH_EN;
  logic [NCH-1:0]    AUTO_EN;
  logic [NCH-1:0]    BUSY;
  logic [NCH-1:0]    REQ;
  logic [IDLE_W-1:0] IDLE_LIMIT;
  logic [NCH-1:0]    ACK;
  logic [NCH-1:0]    CLK_ON;
  logic [NCH-1:0]    GATED_CLK;

  clk_gate_ctrl #(.NCH(NCH), .IDLE_W(IDLE_W), .WAKE_DLY(WAKE_DLY)) dut (
    .CLK(CLK), .RST(RST), .TEST_EN(TEST_EN), .CH_EN(CH_EN), .AUTO_EN(AUTO_EN),
    .BUSY(BUSY), .REQ(REQ), .IDLE_LIMIT(IDLE_LIMIT), .ACK(ACK), .CLK_ON(CLK_ON),
    .GATED_CLK(GATED_CLK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NCH-1:0] gclk;
    logic [NCH-1:0] on;
    logic [NCH-1:0] ack;
  } exp_t;

  exp_t sb[$];
  int   pq[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 1'b0;
  bit   done   = 1'b0;

  logic [NCH-1:0]    s_ch_en = '0, s_auto = '1, s_busy = '0, s_req = '0;
  logic [IDLE_W-1:0] s_lim   = 8'd5;
  bit                s_test  = 1'b0;
  bit                s_rst   = 1'b1;

  // Model: a channel is "powered" from the wake decision until gated off; warm_left counts
  // the edges still needed before the clock is declared stable; quiet is the idle age (-1 = busy).
  bit             m_pow   [NCH];
  int             m_warm  [NCH];
  int             m_quiet [NCH];
  logic [NCH-1:0] m_latch = '0;

  int pulse3 = 0;
  int base3  = 0;
  always @(posedge GATED_CLK[3]) pulse3++;

  function automatic bit m_is_on(int i);
    return m_pow[i] && (m_warm[i] == 0) && (m_quiet[i] < 0);
  endfunction

  function automatic logic [NCH-1:0] m_pow_vec();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = m_pow[i];
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_ack_vec();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = s_req[i] & m_is_on(i);
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pow[i] = 1'b0; m_warm[i] = 0; m_quiet[i] = -1;
    end
  endtask

  task automatic m_step();
    for (int i = 0; i < NCH; i++) begin
      bit want;
      want = s_req[i] | s_busy[i] | ~s_auto[i];
      if (!s_ch_en[i]) begin
        m_pow[i] = 1'b0; m_warm[i] = 0; m_quiet[i] = -1;
      end else if (!m_pow[i]) begin
        if (want) begin m_pow[i] = 1'b1; m_warm[i] = WAKE_DLY; m_quiet[i] = -1; end
      end else if (m_warm[i] > 0) begin
        m_warm[i]--;
      end else if (m_quiet[i] < 0) begin
        if (!want) m_quiet[i] = 0;
      end else if (want) begin
        m_quiet[i] = -1;
      end else if (m_quiet[i] >= int'(s_lim)) begin
        m_pow[i] = 1'b0; m_quiet[i] = -1;
      end else begin
        m_quiet[i] = (m_quiet[i] < 255) ? m_quiet[i] + 1 : 255;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, queue the low-phase and high-phase expectations.
  task automatic cyc(input bit mid_rst = 1'b0, input bit clr = 1'b0);
    exp_t e;
    @(negedge CLK);
    CH_EN = s_ch_en; AUTO_EN = s_auto; BUSY = s_busy; REQ = s_req;
    IDLE_LIMIT = s_lim; TEST_EN = s_test; RST = s_rst;
    if (clr) base3 = pulse3;
    mon_on = 1'b1;
    e.gclk = '0; e.on = m_pow_vec(); e.ack = m_ack_vec();
    sb.push_back(e);
    m_latch = m_pow_vec() | {NCH{s_test}};
    if (s_rst) m_reset(); else m_step();
    e.gclk = m_latch; e.on = m_pow_vec(); e.ack = m_ack_vec();
    sb.push_back(e);
    if (mid_rst) begin
      @(posedge CLK);
      #2;
      s_rst = 1'b1;
      RST   = 1'b1;
      m_reset();
      e.gclk = m_latch; e.on = '0; e.ack = '0;
      sb.push_back(e);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // Monitor: samples 1ns after every clock edge and every reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK or negedge CLK or posedge RST);
      #1;
      if (done) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL scoreboard_drain t=%0t actual=%0d leftover required=0", $time, sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end else if (mon_on) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_underflow t=%0t no expectation queued", $time);
        end else begin
          e = sb.pop_front();
          chk("GATED_CLK", GATED_CLK, e.gclk);
          chk("CLK_ON", CLK_ON, e.on);
          chk("ACK", ACK, e.ack);
        end
        if (pq.size() != 0) begin
          int exp_cnt;
          exp_cnt = pq.pop_front();
          checks++;
          if (pulse3 != exp_cnt) begin
            errors++;
            $display("FAIL idle_pulse_count t=%0t actual=%0d required=%0d",
                     $time, pulse3 - base3, exp_cnt - base3);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t bench did not complete", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    RST = 1'b0; TEST_EN = 1'b0; CH_EN = '0; AUTO_EN = '1; BUSY = '0; REQ = '0; IDLE_LIMIT = 8'd5;
    #1 RST = 1'b1;

    // Reset holds everything off even with requests pending.
    s_ch_en = '1; s_req = '1;
    run(3);
    s_ch_en = '0; s_req = '0; s_rst = 1'b0;
    run(2);

    // Channel 0 without auto-gating: clock stays on, ACK follows REQ once ON.
    s_ch_en[0] = 1'b1; s_auto[0] = 1'b0;
    run(3);
    s_req[0] = 1'b1; run(2);
    s_req[0] = 1'b0; run(1);

    // Channel 1 wake handshake; ACK drops with REQ in the same cycle.
    s_ch_en[1] = 1'b1; s_req[1] = 1'b1;
    run(4);
    s_req[1] = 1'b0;
    run(3);

    // Channel 3 idle timeout with IDLE_LIMIT=5: 7 pulses from the ON->IDLE edge.
    s_lim = 8'd5; s_ch_en[3] = 1'b1; s_busy[3] = 1'b1;
    run(4);
    s_busy[3] = 1'b0;
    cyc(1'b0, 1'b1);
    run(11);
    pq.push_back(base3 + int'(s_lim) + 2);
    // BUSY at idle count 3 returns to ON and restarts the count.
    s_busy[3] = 1'b1; run(4);
    s_busy[3] = 1'b0; run(4);
    s_busy[3] = 1'b1; run(1);
    s_busy[3] = 1'b0; run(10);

    // IDLE_LIMIT=0.
    s_lim = 8'd0;
    s_busy[3] = 1'b1; run(4);
    s_busy[3] = 1'b0; run(4);

    // Channel 2: CH_EN low with REQ rising, then CH_EN dropped during WAKE.
    s_ch_en[2] = 1'b0; s_req[2] = 1'b1;
    run(3);
    s_ch_en[2] = 1'b1; run(1);
    s_ch_en[2] = 1'b0; run(3);
    s_req[2] = 1'b0; run(1);

    // Reset mid high phase with channel 0 ON, then test override under reset.
    cyc(1'b1);
    run(2);
    s_test = 1'b1; run(3);
    s_test = 1'b0; run(2);
    s_rst = 1'b0; run(3);

    // Random traffic.
    s_ch_en = '1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 24) == 0) s_ch_en[i] = ~s_ch_en[i];
        if ($urandom_range(0, 39) == 0) s_auto[i]  = ~s_auto[i];
        if ($urandom_range(0, 7)  == 0) s_req[i]   = ~s_req[i];
        s_busy[i] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 49) == 0) s_lim = 8'($urandom_range(0, 6));
      s_test = ($urandom_range(0, 99) == 0);
      cyc();
    end

    @(posedge CLK);
    #3;
    done = 1'b1;
  end

endmodule
